// File: rtl/vx_axi_write_arb.sv
// vx_axi_write_arb: 2:1 round-robin AXI write arbiter with per-input outstanding limit (VX_AXI_WARB_PERF_EN adds stall counters)
module vx_axi_write_arb #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 512,
  parameter int ID_WIDTH        = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [1:0]                          s_awvalid,
  output logic [1:0]                          s_awready,
  input  logic [1:0][ADDR_WIDTH-1:0]          s_awaddr,
  input  logic [1:0][ID_WIDTH-1:0]            s_awid,
  input  logic [1:0][7:0]                     s_awlen,
  input  logic [1:0]                          s_wvalid,
  output logic [1:0]                          s_wready,
  input  logic [1:0][DATA_WIDTH-1:0]          s_wdata,
  input  logic [1:0][DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic [1:0]                          s_wlast,
  output logic [1:0]                          s_bvalid,
  input  logic [1:0]                          s_bready,
  output logic [1:0][ID_WIDTH-1:0]            s_bid,
  output logic [1:0][1:0]                     s_bresp,
  output logic                                m_awvalid,
  input  logic                                m_awready,
  output logic [ADDR_WIDTH-1:0]               m_awaddr,
  output logic [ID_WIDTH:0]                   m_awid,
  output logic [7:0]                          m_awlen,
  output logic                                m_wvalid,
  input  logic                                m_wready,
  output logic [DATA_WIDTH-1:0]               m_wdata,
  output logic [DATA_WIDTH/8-1:0]             m_wstrb,
  output logic                                m_wlast,
  input  logic                                m_bvalid,
  output logic                                m_bready,
  input  logic [ID_WIDTH:0]                   m_bid,
  input  logic [1:0]                          m_bresp
`ifdef VX_AXI_WARB_PERF_EN
  ,
  output logic [63:0]                         perf_aw_stall,
  output logic [63:0]                         perf_w_stall
`endif
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);
  typedef enum logic {AW_ARB, W_BURST} state_t;
  state_t state;
  logic rr_ptr, w_owner, grant, aw_go, aw_hs, w_act, w_hs, b_sel, b_hs;
  logic [1:0] elig, inc, dec;
  logic [1:0][CW-1:0] outstanding;
  assign elig = {s_awvalid[1] && outstanding[1] < MAX_C, s_awvalid[0] && outstanding[0] < MAX_C};
  assign grant = rr_ptr ? elig[1] : ~elig[0];
  assign aw_go = !reset && state == AW_ARB && |elig;
  assign aw_hs = aw_go && m_awready;
  assign m_awvalid = aw_go;
  assign m_awaddr = s_awaddr[grant];
  assign m_awid = {s_awid[grant], grant};
  assign m_awlen = s_awlen[grant];
  assign s_awready = aw_hs ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign w_act = !reset && state == W_BURST;
  assign m_wvalid = w_act && s_wvalid[w_owner];
  assign s_wready = (w_act && m_wready) ? (w_owner ? 2'b10 : 2'b01) : 2'b00;
  assign m_wdata = s_wdata[w_owner];
  assign m_wstrb = s_wstrb[w_owner];
  assign m_wlast = s_wlast[w_owner];
  assign w_hs = m_wvalid && m_wready;
  assign b_sel = m_bid[0];
  assign s_bvalid = (!reset && m_bvalid) ? (b_sel ? 2'b10 : 2'b01) : 2'b00;
  assign s_bid = {2{m_bid[ID_WIDTH:1]}};
  assign s_bresp = {2{m_bresp}};
  assign m_bready = !reset && s_bready[b_sel];
  assign b_hs = m_bvalid && m_bready;
  assign inc = aw_hs ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign dec = b_hs ? (b_sel ? 2'b10 : 2'b01) : 2'b00;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= AW_ARB;
      rr_ptr <= 1'b0;
      w_owner <= 1'b0;
    end else if (state == AW_ARB) begin
      if (aw_hs) begin
        state <= W_BURST;
        w_owner <= grant;
        rr_ptr <= ~grant;
      end
    end else if (w_hs && m_wlast) begin
      state <= AW_ARB;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        assert (!dec[i] || outstanding[i] != '0);
        if (inc[i] && !dec[i]) outstanding[i] <= outstanding[i] + CW'(1);
        else if (dec[i] && !inc[i] && outstanding[i] != '0) outstanding[i] <= outstanding[i] - CW'(1);
      end
    end
  end
`ifdef VX_AXI_WARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_aw_stall <= '0;
      perf_w_stall <= '0;
    end else begin
      perf_aw_stall <= perf_aw_stall + 64'(m_awvalid && !m_awready);
      perf_w_stall <= perf_w_stall + 64'(m_wvalid && !m_wready);
    end
  end
`endif
endmodule

// File: tb/tb_vx_axi_write_arb.sv
// tb_vx_axi_write_arb: directed checks of arbitration, W ownership, B routing, outstanding limits and reset
module tb_vx_axi_write_arb;
  logic clk = 1'b0, reset;
  logic [1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [1:0][31:0] s_awaddr, s_wdata;
  logic [1:0][7:0] s_awid, s_awlen, s_bid;
  logic [1:0][3:0] s_wstrb;
  logic [1:0][1:0] s_bresp;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [31:0] m_awaddr, m_wdata;
  logic [8:0] m_awid, m_bid;
  logic [7:0] m_awlen;
  logic [3:0] m_wstrb;
  logic [1:0] m_bresp;
  int n_tests = 0, n_fail = 0;
  vx_axi_write_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    s_awvalid = '0; s_awaddr = '0; s_awid = '0; s_awlen = '0;
    s_wvalid = '0; s_wdata = '0; s_wstrb = '1; s_wlast = '0; s_bready = '0;
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_bid = '0; m_bresp = '0;
  endtask
  task automatic bresp(input logic s);
    m_bid = {8'h00, s}; m_bvalid = 1'b1; s_bready = 2'b11;
    step();
    m_bvalid = 1'b0; s_bready = 2'b00;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    idle();
    reset = 1'b1;
    s_awvalid = 2'b11; s_wvalid = 2'b11; m_bvalid = 1'b1; s_bready = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_awready", s_awready, 0);
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_wready", s_wready, 0);
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_bready", m_bready, 0);
    chk("rst_cnt", dut.outstanding, 0);
    idle();
    reset = 1'b0;
    s_awid = {8'h22, 8'h11}; s_wdata = {32'hBBBB0001, 32'hAAAA0000};
    s_wlast = 2'b11; s_wvalid = 2'b11; s_awvalid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("alt_awid", m_awid, k[0] ? 9'h045 : 9'h022);
      chk("alt_awready", s_awready, k[0] ? 2'b10 : 2'b01);
      chk("alt_no_w", m_wvalid, 0);
      step();
      chk("alt_wready", s_wready, k[0] ? 2'b10 : 2'b01);
      chk("alt_wdata", m_wdata, k[0] ? 32'hBBBB0001 : 32'hAAAA0000);
      chk("alt_no_aw", m_awvalid, 0);
      step();
    end
    chk("both_full_block", m_awvalid, 0);
    chk("cnt_full", dut.outstanding, 4'hA);
    s_awvalid = 2'b00; s_wvalid = 2'b00;
    m_bid = 9'h0B5; m_bresp = 2'b10; m_bvalid = 1'b1; s_bready = 2'b00;
    #1;
    chk("b_route", s_bvalid, 2'b10);
    chk("b_id", s_bid[1], 8'h5A);
    chk("b_resp", s_bresp[1], 2'b10);
    chk("b_ready_low", m_bready, 0);
    step();
    chk("b_no_dec", dut.outstanding, 4'hA);
    s_bready = 2'b10;
    #1;
    chk("b_ready_high", m_bready, 1);
    step();
    m_bvalid = 1'b0; s_bready = 2'b00;
    chk("b_dec_once", dut.outstanding, 4'h6);
    bresp(1'b1); bresp(1'b0); bresp(1'b0);
    chk("drain", dut.outstanding, 0);
    s_awvalid = 2'b11; s_awaddr[0] = 32'h1000; s_awlen = {8'd0, 8'd3}; s_awid = {8'h33, 8'h44};
    s_wvalid = 2'b11; s_wlast = 2'b10;
    #1;
    chk("burst_awaddr", m_awaddr, 32'h1000);
    chk("burst_awlen", m_awlen, 3);
    chk("burst_awready", s_awready, 2'b01);
    step();
    s_awvalid = 2'b10; s_wdata[0] = 32'hFF; m_wready = 1'b0;
    #1;
    chk("wstall_valid", m_wvalid, 1);
    chk("wstall_ready", s_wready, 0);
    step();
    m_wready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s_wdata[0] = 32'(b); s_wlast[0] = (b == 3);
      #1;
      chk("burst_wvalid", m_wvalid, 1);
      chk("burst_wready", s_wready, 2'b01);
      chk("burst_wdata", m_wdata, b);
      chk("burst_wlast", m_wlast, b == 3);
      chk("burst_no_aw", m_awvalid, 0);
      step();
    end
    chk("post_awid", m_awid, 9'h067);
    chk("post_awready", s_awready, 2'b10);
    chk("post_no_w", m_wvalid, 0);
    step();
    s_awvalid = 2'b00;
    #1;
    chk("in1_wready", s_wready, 2'b10);
    step();
    chk("cnt_after_burst", dut.outstanding, 4'h5);
    bresp(1'b0); bresp(1'b1);
    s_awvalid = 2'b01; s_wvalid = 2'b11; s_wlast = 2'b11;
    repeat (4) step();
    chk("lim_cnt", dut.outstanding, 4'h2);
    chk("lim_stall", m_awvalid, 0);
    chk("lim_stall_ready", s_awready, 0);
    s_awvalid = 2'b11;
    #1;
    chk("lim_other_valid", m_awvalid, 1);
    chk("lim_other_ready", s_awready, 2'b10);
    step();
    s_awvalid = 2'b01;
    step();
    chk("lim_still_stall", m_awvalid, 0);
    m_bid = 9'h000; m_bvalid = 1'b1; s_bready = 2'b01;
    #1;
    chk("lim_b_ready", m_bready, 1);
    step();
    m_bvalid = 1'b0; s_bready = 2'b00;
    chk("lim_release", s_awready, 2'b01);
    step();
    step();
    chk("lim_cnt2", dut.outstanding, 4'h6);
    bresp(1'b0);
    m_bid = 9'h000; m_bvalid = 1'b1; s_bready = 2'b01;
    #1;
    chk("same_aw", s_awready, 2'b01);
    chk("same_b", m_bready, 1);
    step();
    m_bvalid = 1'b0; s_bready = 2'b00;
    chk("same_cnt", dut.outstanding, 4'h5);
    step();
    s_awlen[0] = 8'd3; s_wlast = 2'b00;
    step();
    step();
    reset = 1'b1;
    #1;
    chk("rst_mid_w", m_wvalid, 0);
    step();
    reset = 1'b0; s_awvalid = 2'b11;
    #1;
    chk("rst_mid_cnt", dut.outstanding, 0);
    chk("rst_mid_no_w", m_wvalid, 0);
    chk("rst_mid_rr", s_awready, 2'b01);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vx_axi_write_arb.md
VX_AXI_WRITE_ARB -- requirements
Module: VX_axi_write_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AW address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 512, W data width; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have parameter ID_WIDTH, default 8, per-input AXI ID width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4 (range 1..255), the per-input limit on AW issued without a B response.
REQ-005 SHALL have a single clock, and its reset SHALL be synchronous and active-high:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
REQ-006 SHALL have the slave-side ports, indexed by input i:
- s_awvalid  in  2  per-input AW valid
- s_awready  out  2  per-input AW ready
- s_awaddr  in  2xADDR_WIDTH  per-input AW address
- s_awid  in  2xID_WIDTH  per-input AW ID
- s_awlen  in  2x8  per-input burst length minus one
- s_wvalid / s_wready  in / out  2 / 2  per-input W handshake
- s_wdata / s_wstrb / s_wlast  in  2xDATA_WIDTH / 2xDATA_WIDTH/8 / 2  per-input W payload
- s_bvalid / s_bready  out / in  2 / 2  per-input B handshake
- s_bid / s_bresp  out  2xID_WIDTH / 2x2  per-input B payload
REQ-007 SHALL have the master-side ports:
- m_awvalid / m_awready  out / in  1 / 1  AW handshake
- m_awaddr / m_awid / m_awlen  out  ADDR_WIDTH / ID_WIDTH+1 / 8  AW payload
- m_wvalid / m_wready  out / in  1 / 1  W handshake
- m_wdata / m_wstrb / m_wlast  out  DATA_WIDTH / DATA_WIDTH/8 / 1  W payload
- m_bvalid / m_bready  in / out  1 / 1  B handshake
- m_bid / m_bresp  in  ID_WIDTH+1 / 2  B payload

Function
REQ-008 SHALL implement a two-state write FSM: AW_ARB and W_BURST.
REQ-009 In AW_ARB, SHALL grant round-robin, starting at rr_ptr, among inputs with s_awvalid=1 and outstanding[i] < MAX_OUTSTANDING; m_awvalid SHALL be combinational from the winner (zero added latency).
REQ-010 SHALL set m_awid = {s_awid[grant], grant}, so the select bit is bit 0; addr and len SHALL pass unchanged.
REQ-011 s_awready[grant] SHALL equal m_awready in AW_ARB; every other s_awready SHALL be 0; all s_awready SHALL be 0 in W_BURST.
REQ-012 On an AW handshake, SHALL latch grant into w_owner, set rr_ptr = grant+1 (mod 2), and enter W_BURST on the next cycle.
REQ-013 In W_BURST, SHALL connect W to w_owner only: m_wvalid=s_wvalid[w_owner] and s_wready[w_owner]=m_wready; the other s_wready SHALL be 0.
REQ-014 SHALL return to AW_ARB on the cycle after the W handshake with m_wlast=1; beat count is not checked.
REQ-015 No W beat SHALL pass in AW_ARB (m_wvalid=0); AW and W SHALL never handshake in the same cycle.
REQ-016 SHALL route B responses by m_bid[0]: s_bvalid[m_bid[0]]=m_bvalid, s_bid=m_bid[ID_WIDTH:1], s_bresp=m_bresp, m_bready=s_bready[m_bid[0]]; the other s_bvalid SHALL be 0.
REQ-017 outstanding[i] SHALL have width clog2(MAX_OUTSTANDING+1); +1 on an AW handshake from i, -1 on a B handshake to i; both in the same cycle SHALL leave it unchanged.
REQ-018 An input at MAX_OUTSTANDING SHALL be skipped by arbitration and SHALL NOT block the other input.
REQ-019 A B handshake with outstanding[i]=0 SHALL leave the counter at 0 (saturate); it is flagged by assertion in simulation.

Reset
REQ-020 On reset, SHALL set FSM=AW_ARB, rr_ptr=0, w_owner=0, and all outstanding=0.
REQ-021 During reset, all valid and ready outputs SHALL be 0; reset applied in W_BURST SHALL abandon the burst.

Configuration
REQ-022 With VX_AXI_WARB_PERF_EN defined, SHALL add outputs perf_aw_stall (64) and perf_w_stall (64), reset to 0:
- perf_aw_stall counts cycles with m_awvalid & ~m_awready.
- perf_w_stall counts cycles with m_wvalid & ~m_wready.
REQ-023 Without VX_AXI_WARB_PERF_EN, those ports and counters SHALL NOT exist; function is otherwise identical.

Verification
REQ-024 Both inputs issue AW continuously, 1-beat bursts, m_awready=1 -> grants alternate 0,1,0,1; m_awid[0] follows the grant.
REQ-025 Input 0 AW awlen=3, input 1 W asserted early -> 4 beats from input 0 only, then input 1 AW is accepted; input 1 W is never forwarded in between.
REQ-026 MAX_OUTSTANDING=2, B held off, input 0 issues 3 AWs -> third AW stalls, input 1 AW still granted; a B with m_bid[0]=0 releases the third AW.
REQ-027 m_bid={8'h5A,1'b1}, m_bvalid=1, s_bready[1]=0 then 1 -> s_bvalid[1]=1, s_bid[1]=8'h5A, m_bready follows s_bready[1], and outstanding[1] decrements once.
REQ-028 AW handshake and B handshake for input 0 in the same cycle at count 1 -> count stays 1.
REQ-029 Reset pulsed in W_BURST mid-burst -> next cycle FSM=AW_ARB, counters=0, m_wvalid=0.
